pipe_stage_skid: RTL

Parametrised successor of the fixed IF/ID pipeline register. It is a generic W-bit pipeline stage with a valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble insertion. Any stage boundary (F/D, D/E, E/M, M/W) instantiates it, replacing the per-stage hand-written registers and their separate EN/clear wiring. Downstream back-pressure is fully registered: in_ready comes from a flop, not from out_ready.

---
 rtl/pipe_stage_skid.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic WIDTH-bit pipeline stage with valid/ready handshake,
// a one-entry skid buffer, synchronous flush and bubble insertion. It replaces
// the hand-written per-stage pipeline registers (F/D, D/E, E/M, M/W) and their
// separate enable/clear wiring.
//
// Upstream back-pressure is fully registered: in_ready comes straight from a
// flop, so there is no combinational path from out_ready or in_valid to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream holds a valid payload
//   in_ready   stage can accept a payload this cycle (registered)
//   in_data    upstream payload
//   out_valid  out_data carries a valid payload (registered)
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to the next stage (registered, BUBBLE_VAL when empty)
//   flush      discard every held and incoming payload at the next edge
//   occupancy  number of payloads held: 0, 1 or 2 (registered)
//
// Optional build macro PIPE_STAGE_PERF_EN adds two saturating 32-bit counters:
//   stall_cnt   cycles with out_valid=1 and out_ready=0
//   bubble_cnt  cycles with out_valid=0 and out_ready=1
// Both are cleared only by reset. Handshake behaviour is identical either way.

module pipe_stage_skid #(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  localparam int unsigned OCC_W = 2;

  // State is the pair (m_valid, s_valid); (0,1) is illegal.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   m_data_q;
  logic [WIDTH-1:0]   m_data_d;
  logic [WIDTH-1:0]   s_data_q;
  logic [WIDTH-1:0]   s_data_d;
  logic               in_ready_q;
  logic               in_ready_d;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;

  logic               m_valid;
  logic               s_valid;
  logic               in_xfer;
  logic               out_xfer;

  assign m_valid  = state_q[1];
  assign s_valid  = state_q[0];
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = m_valid & out_ready;

  // State register: storage for both entries plus the registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      m_data_q   <= BUBBLE_VAL;
      s_data_q   <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  // Next-state logic. Flush overrides everything, dropping a coincident input
  // even though the upstream handshake completed.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      m_data_d = BUBBLE_VAL;
      s_data_d = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d  = ST_ONE;
            m_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_data_d = in_data;
          end else if (in_xfer) begin
            // Downstream stalled: park the new payload in the skid entry.
            s_data_d = in_data;
            state_d  = ST_FULL;
          end else if (out_xfer) begin
            m_data_d = BUBBLE_VAL;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path can fire.
          if (out_xfer) begin
            m_data_d = s_data_q;
            s_data_d = BUBBLE_VAL;
            state_d  = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          m_data_d = BUBBLE_VAL;
          s_data_d = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Output logic: next values of the registered status outputs, derived from
  // the next state so in_ready and occupancy stay flop-driven.
  always_comb begin
    in_ready_d = 1'b1;
    occ_d      = '0;
    in_ready_d = ~state_d[0];
    occ_d      = OCC_W'(state_d[1]) + OCC_W'(state_d[0]);
  end

  assign out_valid = m_valid;
  assign out_data  = m_data_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occ_q;

  // The skid entry is only ever filled behind a valid main entry.
  a_skid_implies_main : assert property (@(posedge clk) disable iff (reset) s_valid |-> m_valid);

`ifdef PIPE_STAGE_PERF_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (m_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!m_valid && out_ready && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
